pid_pwm_out: RTL and testbench
==============================

// Module: pid_pwm_out
// PURPOSE
//  Downstream stage of the PID controller: consumes the signed controller output uk0 and drives
//  a sign/magnitude PWM actuator (pwm + dir). Converts |uk0| to a clamped duty cycle and double-
//  buffers it so duty changes only at period boundaries. Enforces a dead interval on reversal.
// PARAMETERS
//  UK_W      15    width of signed controller output uk0
//  CNT_W     10    width of period counter and duty
//  PERIOD    1000  PWM period in clk cycles (2..2**CNT_W)
//  DUTY_MAX  950   duty ceiling in cycles (<= PERIOD)
//  SHIFT     0     right-shift applied to |uk0| before clamping (gain scaling)
//  DEAD_CYC  8     forced-low cycles inserted when direction reverses (>=1)
// PORTS
//  clk        in   1      system clock
//  rst_n      in   1      asynchronous active-low reset
//  en         in   1      run enable; low = outputs idle
//  uk0        in   UK_W   signed PID output sample
//  uk_valid   in   1      one-cycle strobe: uk0 valid this cycle
//  pwm        out  1      PWM drive, registered
//  dir        out  1      direction: 0 = uk>=0, 1 = uk<0, registered
//  duty       out  CNT_W  duty applied in the current period
//  sat        out  1      1 = duty of current period was clamped to DUTY_MAX
//  period_end out  1      one-cycle pulse on the last cycle of each period
// BEHAVIOUR
//  - Reset (async, rst_n=0): all outputs 0; cnt=0; shadow duty/dir/sat=0; state IDLE.
//  - Conversion: mag = |uk0| in UK_W unsigned bits (-2**(UK_W-1) maps to 2**(UK_W-1), no wrap).
//    m = mag >> SHIFT; if m > DUTY_MAX then duty=DUTY_MAX, sat=1, else duty=m, sat=0.
//    dir = uk0[UK_W-1]. uk0 = 0 -> duty 0, dir 0.
//  - Capture: on uk_valid the converted {duty,dir,sat} is written to the shadow register
//    (visible 1 cycle later). Samples arriving without en are still captured.
//  - States: IDLE, RUN, DEAD.
//    IDLE: pwm=0, cnt=0, period_end=0. en=1 -> load shadow into active, RUN at cnt=0.
//    RUN:  pwm = (cnt < duty_act); cnt increments; at cnt==PERIOD-1: period_end=1, cnt->0,
//          load shadow; if shadow dir != active dir -> DEAD, else stay RUN.
//    DEAD: pwm=0, dir held at old value; count DEAD_CYC cycles; then dir updates to new,
//          RUN at cnt=0 with the duty loaded at the boundary. period_end not pulsed in DEAD.
//  - Latency: uk_valid at cycle t affects pwm from the first period start after t+1.
//  - uk_valid coincident with cnt==PERIOD-1: incoming sample bypasses shadow and is applied
//    to the next period directly.
//  - duty=0: pwm stays 0 all period; duty=PERIOD: pwm high whole period (no glitch at wrap).
//  - en deasserted in RUN or DEAD: next cycle IDLE, pwm=0, cnt=0; active dir/duty retained
//    on outputs until the next load. Shadow is preserved.
//  - Reset mid-period: immediate async return to reset values; no partial pulse afterwards.
//  - All outputs registered; no combinational path from uk0 to pwm.
// STRUCTURE
//  - pid_pkg: UK_W, CNT_W defaults; state encoding localparams (IDLE/RUN/DEAD).
//  - Sub-module pid_duty_conv: combinational abs/shift/clamp -> {duty,dir,sat}.
//  - Top holds shadow/active registers, period counter, dead counter, FSM.
// TESTING (PERIOD=1000, DUTY_MAX=950, SHIFT=0, DEAD_CYC=8)
//  1 uk0=300 strobe, en=1 -> next period: pwm high 300, low 700, dir=0, sat=0; period_end each 1000.
//  2 after 1, uk0=-200 -> at boundary 8 cycles pwm=0 with dir=0, then dir=1, pwm high 200/1000.
//  3 uk0=2000 then uk0=-16384 -> duty=950 sat=1 dir=0; then dead interval, duty=950 sat=1 dir=1.
//  4 uk_valid with uk0=500 on the cnt==999 cycle -> following period duty=500 (bypass path).
//  5 en=0 at cnt=150 with duty 300 -> pwm=0 next cycle, cnt=0; en=1 -> fresh period, 300 high.
//  6 rst_n pulsed low mid-pulse -> pwm,dir,duty,sat,period_end=0 immediately; IDLE until reload.

Source files
------------

// File: rtl/pid_pkg.sv
// Shared defaults and FSM encoding for the PID actuator output stage.
// Latency: n/a (types only).
// Backpressure: n/a.
package pid_pkg;

  localparam int UK_W_DEF  = 15;
  localparam int CNT_W_DEF = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DEAD = 2'd2
  } pwm_state_t;

endpackage

// File: rtl/pid_duty_conv.sv
// Signed controller sample -> clamped sign/magnitude duty {duty, dir, sat}.
// Latency: combinational.
// Backpressure: none; pure function of uk.
module pid_duty_conv #(
  parameter int UK_W     = 15,
  parameter int CNT_W    = 10,
  parameter int DUTY_MAX = 950,
  parameter int SHIFT    = 0
) (
  input  logic [UK_W-1:0]  uk,
  output logic [CNT_W-1:0] duty,
  output logic             dir,
  output logic             sat
);

  // One extra bit so the clamp compare is unsigned and never truncates either side.
  localparam int CW = ((UK_W > CNT_W) ? UK_W : CNT_W) + 1;

  logic [UK_W-1:0] mag;
  logic [UK_W-1:0] mag_sh;
  logic [CW-1:0]   mag_ext;

  always_comb begin
    // Most-negative input maps to 2**(UK_W-1), which still fits UK_W unsigned bits.
    mag     = uk[UK_W-1] ? (~uk + UK_W'(1)) : uk;
    mag_sh  = mag >> SHIFT;
    mag_ext = CW'(mag_sh);
    dir     = uk[UK_W-1];
    if (mag_ext > CW'(DUTY_MAX)) begin
      duty = CNT_W'(DUTY_MAX);
      sat  = 1'b1;
    end else begin
      duty = CNT_W'(mag_sh);
      sat  = 1'b0;
    end
  end

endmodule

// File: rtl/pid_pwm_out.sv
// Sign/magnitude PWM driver: double-buffered duty, period-aligned updates, dead time on reversal.
// Latency: sample at t applies from the first period start after t+1; all outputs registered.
// Backpressure: none; uk_valid is always accepted, last sample before a boundary wins.
module pid_pwm_out
  import pid_pkg::*;
#(
  parameter int UK_W     = UK_W_DEF,
  parameter int CNT_W    = CNT_W_DEF,
  parameter int PERIOD   = 1000,
  parameter int DUTY_MAX = 950,
  parameter int SHIFT    = 0,
  parameter int DEAD_CYC = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [UK_W-1:0]  uk0,
  input  logic             uk_valid,
  output logic             pwm,
  output logic             dir,
  output logic [CNT_W-1:0] duty,
  output logic             sat,
  output logic             period_end
);

  localparam int               DEAD_W    = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(PERIOD - 1);
  localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEAD_CYC - 1);

  pwm_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DEAD_W-1:0] dead_q, dead_d;

  logic [CNT_W-1:0]  sh_duty;
  logic              sh_dir, sh_sat;

  logic [CNT_W-1:0]  c_duty;
  logic              c_dir, c_sat;

  logic [CNT_W-1:0]  ld_duty, duty_d;
  logic              ld_dir, ld_sat, dir_d, sat_d;
  logic              pwm_d, pe_d;

  pid_duty_conv #(
    .UK_W     (UK_W),
    .CNT_W    (CNT_W),
    .DUTY_MAX (DUTY_MAX),
    .SHIFT    (SHIFT)
  ) u_conv (
    .uk   (uk0),
    .duty (c_duty),
    .dir  (c_dir),
    .sat  (c_sat)
  );

  // A sample landing on the boundary cycle would miss the shadow, so take it directly.
  always_comb begin
    ld_duty = uk_valid ? c_duty : sh_duty;
    ld_dir  = uk_valid ? c_dir  : sh_dir;
    ld_sat  = uk_valid ? c_sat  : sh_sat;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dead_d  = dead_q;
    duty_d  = duty;
    dir_d   = dir;
    sat_d   = sat;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d  = '0;
        dead_d = '0;
        if (en) begin
          duty_d  = sh_duty;
          dir_d   = sh_dir;
          sat_d   = sh_sat;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!en) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d  = '0;
          duty_d = ld_duty;
          sat_d  = ld_sat;
          dead_d = '0;
          if (ld_dir != dir) state_d = ST_DEAD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DEAD: begin
        if (!en) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          dead_d  = '0;
        end else if (dead_q == DEAD_LAST) begin
          // Entry to DEAD only happens on a reversal, so the new direction is the inverse.
          dir_d   = ~dir;
          state_d = ST_RUN;
          cnt_d   = '0;
          dead_d  = '0;
        end else begin
          dead_d = dead_q + DEAD_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        dead_d  = '0;
      end
    endcase
    // Outputs are computed from next-state so pwm/period_end line up with the cnt register.
    pwm_d = (state_d == ST_RUN) && (cnt_d < duty_d);
    pe_d  = (state_d == ST_RUN) && (cnt_d == CNT_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      dead_q     <= '0;
      duty       <= '0;
      dir        <= 1'b0;
      sat        <= 1'b0;
      pwm        <= 1'b0;
      period_end <= 1'b0;
      sh_duty    <= '0;
      sh_dir     <= 1'b0;
      sh_sat     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dead_q     <= dead_d;
      duty       <= duty_d;
      dir        <= dir_d;
      sat        <= sat_d;
      pwm        <= pwm_d;
      period_end <= pe_d;
      if (uk_valid) begin
        sh_duty <= c_duty;
        sh_dir  <= c_dir;
        sh_sat  <= c_sat;
      end
    end
  end

endmodule

// File: tb/tb_pid_pwm_out.sv
// Scoreboard bench for pid_pwm_out: per-period window records compared against hand-computed values.
module tb_pid_pwm_out;

  logic        clk = 1'b0;
  logic        rst_n, en, uk_valid;
  logic [14:0] uk0;
  logic        pwm, dir, sat, period_end;
  logic [9:0]  duty;

  always #5 clk = ~clk;

  pid_pwm_out #(
    .UK_W(15), .CNT_W(10), .PERIOD(1000), .DUTY_MAX(950), .SHIFT(0), .DEAD_CYC(8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .uk0        (uk0),
    .uk_valid   (uk_valid),
    .pwm        (pwm),
    .dir        (dir),
    .duty       (duty),
    .sat        (sat),
    .period_end (period_end)
  );

  // One record per window ending in period_end: length, first high cycle, high count,
  // direction at window start and end, duty and sat shown at the end.
  typedef struct packed {
    logic [15:0] len;
    logic [15:0] first_hi;
    logic [15:0] hi;
    logic        dir_s;
    logic        dir_e;
    logic [9:0]  duty;
    logic        sat;
  } rec_t;

  localparam int NONE = 16'hFFFF;

  rec_t exp_q[$];
  rec_t cur, exp_r;
  int   checks   = 0;
  int   failures = 0;
  int   clr_req  = 0;
  int   clr_seen = 0;

  function automatic rec_t mk(input int len, input int first_hi, input int hi,
                              input bit ds, input bit de, input int d, input bit s);
    rec_t r;
    r.len      = len[15:0];
    r.first_hi = first_hi[15:0];
    r.hi       = hi[15:0];
    r.dir_s    = ds;
    r.dir_e    = de;
    r.duty     = d[9:0];
    r.sat      = s;
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, act, expv);
    end
  endtask

  // Monitor: builds a window record every negedge and scores it on period_end.
  always @(negedge clk) begin
    if (!rst_n || !en || clr_seen != clr_req) begin
      cur          = '0;
      cur.first_hi = NONE[15:0];
      clr_seen     = clr_req;
    end else begin
      if (cur.len == 16'd0) cur.dir_s = dir;
      if (pwm && cur.first_hi == NONE[15:0]) cur.first_hi = cur.len;
      if (pwm) cur.hi = cur.hi + 16'd1;
      cur.len = cur.len + 16'd1;
      if (period_end) begin
        cur.dir_e = dir;
        cur.duty  = duty;
        cur.sat   = sat;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_period got len=%0d hi=%0d duty=%0d exp none", cur.len, cur.hi, cur.duty);
        end else begin
          exp_r = exp_q.pop_front();
          if (cur != exp_r) begin
            failures++;
            $display("FAIL period got len=%0d first=%0d hi=%0d dir=%0b->%0b duty=%0d sat=%0b exp len=%0d first=%0d hi=%0d dir=%0b->%0b duty=%0d sat=%0b",
                     cur.len, cur.first_hi, cur.hi, cur.dir_s, cur.dir_e, cur.duty, cur.sat,
                     exp_r.len, exp_r.first_hi, exp_r.hi, exp_r.dir_s, exp_r.dir_e, exp_r.duty, exp_r.sat);
          end
        end
        cur          = '0;
        cur.first_hi = NONE[15:0];
      end
    end
  end

  task automatic strobe(input int v);
    uk0      = v[14:0];
    uk_valid = 1'b1;
    @(posedge clk); #1;
    uk_valid = 1'b0;
  endtask

  task automatic enable();
    en = 1'b1;
    clr_req++;
    @(posedge clk); #1;
  endtask

  // Returns just after the boundary edge, i.e. on cnt==0 of the following period.
  task automatic wait_pe(input int n);
    int seen = 0;
    int t    = 0;
    while (seen < n && t < n * 1100) begin
      @(negedge clk);
      t++;
      if (period_end) seen++;
    end
    if (seen < n) chk("period_end_timeout", seen, n);
    @(posedge clk); #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pwm"},  int'(pwm),        0);
    chk({tag, "_dir"},  int'(dir),        0);
    chk({tag, "_duty"}, int'(duty),       0);
    chk({tag, "_sat"},  int'(sat),        0);
    chk({tag, "_pe"},   int'(period_end), 0);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; uk_valid = 1'b0; uk0 = '0;
    repeat (3) @(posedge clk); #1;
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: +300 -> 300 high / 700 low, dir 0
    strobe(300);
    repeat (3) exp_q.push_back(mk(1000, 0, 300, 0, 0, 300, 0));
    enable();
    wait_pe(3);

    // 2: reverse to -200 -> dead interval then 200 high with dir 1
    strobe(-200);
    exp_q.push_back(mk(1000, 0, 300, 0, 0, 300, 0));
    exp_q.push_back(mk(1008, 8, 200, 0, 1, 200, 0));
    wait_pe(2);

    // 3: saturation both signs
    strobe(2000);
    exp_q.push_back(mk(1000, 0, 200, 1, 1, 200, 0));
    exp_q.push_back(mk(1008, 8, 950, 1, 0, 950, 1));
    wait_pe(2);
    strobe(-16384);
    exp_q.push_back(mk(1000, 0, 950, 0, 0, 950, 1));
    exp_q.push_back(mk(1008, 8, 950, 0, 1, 950, 1));
    wait_pe(2);

    // 4: sample on the last cycle bypasses the shadow
    exp_q.push_back(mk(1000, 0, 950, 1, 1, 950, 1));
    exp_q.push_back(mk(1008, 8, 500, 1, 0, 500, 0));
    repeat (999) @(posedge clk);
    #1;
    chk("pe_on_last_cycle", int'(period_end), 1);
    strobe(500);
    wait_pe(1);

    // 5: en drop mid-pulse, then fresh period
    exp_q.push_back(mk(1000, 0, 500, 0, 0, 500, 0));
    strobe(300);
    wait_pe(1);
    repeat (150) @(posedge clk);
    #1;
    chk("pwm_before_en_off", int'(pwm), 1);
    en = 1'b0;
    @(posedge clk); #1;
    chk("pwm_after_en_off", int'(pwm), 0);
    chk("duty_held_en_off", int'(duty), 300);
    chk("dir_held_en_off", int'(dir), 0);
    repeat (20) @(posedge clk);
    #1;
    chk("pwm_idle", int'(pwm), 0);
    repeat (2) exp_q.push_back(mk(1000, 0, 300, 0, 0, 300, 0));
    enable();
    wait_pe(2);

    // 6: async reset mid-pulse
    repeat (100) @(posedge clk);
    #1;
    chk("pwm_before_reset", int'(pwm), 1);
    #2;
    rst_n = 1'b0;
    en    = 1'b0;
    #1;
    chk_all_zero("async_reset");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("pwm_idle_after_reset", int'(pwm), 0);
    chk("duty_idle_after_reset", int'(duty), 0);

    // Negative load from IDLE takes dir directly; then zero duty across a reversal
    strobe(-100);
    exp_q.push_back(mk(1000, 0, 100, 1, 1, 100, 0));
    exp_q.push_back(mk(1008, NONE, 0, 1, 0, 0, 0));
    enable();
    repeat (5) @(posedge clk);
    #1;
    strobe(0);
    wait_pe(2);
    repeat (3) @(posedge clk);
    #1;
    chk("expected_queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
